game_sequencer: RTL and testbench



---
 rtl/flappy_pkg.sv | 32 +++
 rtl/key_debounce.sv | 56 +++++
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and helpers for the flappy game controller: game state encoding and
// the two-digit BCD score with its saturating increment.
package flappy_pkg;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    PLAY    = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  // Tens in the upper nibble, so a plain vector compare orders scores correctly.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for an active-low push key;
// press_evt pulses for one cycle when the debounced level falls.
module key_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press_evt
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, making the sync chain a real two-stage shift.
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level     = level_q;
  assign press_evt = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: debounced frame-aligned flap, ATTRACT/PLAY/DYING/OVER FSM and BCD score.
// Define HIGH_SCORE_EN to add the best_ones/best_tens high-score outputs.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int fA           = 32,
  parameter int DB_CYCLES    = 250000,
  parameter int DEATH_FRAMES = 60,
  parameter int OVER_FRAMES  = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [fA-1:0] frame_id,
  input  logic          key_n,
  input  logic          hit,
  input  logic          pipe_passed,
  output logic          frame_tick,
  output logic          flap,
  output logic          world_run,
  output logic          bird_run,
  output logic [1:0]    game_state,
  output logic [3:0]    score_ones,
  output logic [3:0]    score_tens
`ifdef HIGH_SCORE_EN
  ,
  output logic [3:0]    best_ones,
  output logic [3:0]    best_tens
`endif
);

  localparam int            FMAX       = (DEATH_FRAMES > OVER_FRAMES) ? DEATH_FRAMES : OVER_FRAMES;
  localparam int            FW         = $clog2(FMAX + 1);
  localparam logic [FW-1:0] DEATH_LAST = FW'(DEATH_FRAMES - 1);
  localparam logic [FW-1:0] OVER_SAT   = FW'(OVER_FRAMES);

  logic          press_evt;
  logic          key_level_unused;  // debounced level is only of interest for debug

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_debounce (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .level    (key_level_unused),
    .press_evt(press_evt)
  );

  logic [fA-1:0] frame_id_q;
  logic          tick_d;
  game_state_t   state_q, state_d;
  bcd2_t         score_q, score_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic          frame_tick_q, flap_q, flap_d;
  logic          world_run_q, world_run_d;
  logic          bird_run_q, bird_run_d;
`ifdef HIGH_SCORE_EN
  bcd2_t         best_q, best_d;
`endif

  always_comb begin
    tick_d  = (frame_id != frame_id_q);
    state_d = state_q;
    score_d = score_q;
    fcnt_d  = fcnt_q;
    pend_d  = 1'b0;
`ifdef HIGH_SCORE_EN
    best_d  = best_q;
`endif
    unique case (state_q)
      ATTRACT: begin
        if (press_evt) begin
          state_d = PLAY;
          score_d = '0;
          fcnt_d  = '0;
          pend_d  = 1'b1;
        end
      end
      PLAY: begin
        // A pending flap survives until the next frame boundary; extra presses merge into it.
        pend_d = (pend_q & ~tick_d) | press_evt;
        if (hit) begin
          state_d = DYING;
          fcnt_d  = '0;
          pend_d  = 1'b0;
`ifdef HIGH_SCORE_EN
          if (score_q > best_q) best_d = score_q;
`endif
        end else if (pipe_passed) begin
          score_d = bcd2_inc(score_q);
        end
      end
      DYING: begin
        if (tick_d) begin
          if (fcnt_q == DEATH_LAST) begin
            state_d = OVER;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (tick_d && fcnt_q != OVER_SAT) fcnt_d = fcnt_q + 1'b1;
        if (press_evt && fcnt_q == OVER_SAT) begin
          state_d = ATTRACT;
          fcnt_d  = '0;
        end
      end
      default: state_d = ATTRACT;
    endcase
    flap_d      = tick_d & pend_q & (state_q == PLAY);
    world_run_d = (state_d == PLAY);
    bird_run_d  = (state_d == PLAY) || (state_d == DYING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_id_q   <= frame_id;
      state_q      <= ATTRACT;
      score_q      <= '0;
      fcnt_q       <= '0;
      pend_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      flap_q       <= 1'b0;
      world_run_q  <= 1'b0;
      bird_run_q   <= 1'b0;
`ifdef HIGH_SCORE_EN
      best_q       <= '0;
`endif
    end else begin
      frame_id_q   <= frame_id;
      state_q      <= state_d;
      score_q      <= score_d;
      fcnt_q       <= fcnt_d;
      pend_q       <= pend_d;
      frame_tick_q <= tick_d;
      flap_q       <= flap_d;
      world_run_q  <= world_run_d;
      bird_run_q   <= bird_run_d;
`ifdef HIGH_SCORE_EN
      best_q       <= best_d;
`endif
    end
  end

  assign frame_tick = frame_tick_q;
  assign flap       = flap_q;
  assign world_run  = world_run_q;
  assign bird_run   = bird_run_q;
  assign game_state = state_q;
  assign score_ones = score_q.ones;
  assign score_tens = score_q.tens;
`ifdef HIGH_SCORE_EN
  assign best_ones  = best_q.ones;
  assign best_tens  = best_q.tens;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a vector table for reset/key/first-flap timing,
// then hand-written game sequences; expectations flow through a scoreboard queue.
module tb_game_sequencer;
  import flappy_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic        hit = 1'b0;
  logic        pipe_passed = 1'b0;
  logic [31:0] frame_id = 32'd7;
  logic        frame_tick, flap, world_run, bird_run;
  logic [1:0]  game_state;
  logic [3:0]  score_ones, score_tens;
`ifdef HIGH_SCORE_EN
  logic [3:0]  best_ones, best_tens;
`endif

  always #5 clk = ~clk;

  game_sequencer #(
    .fA(32), .DB_CYCLES(4), .DEATH_FRAMES(3), .OVER_FRAMES(5)
  ) dut (
    .clk(clk), .rst(rst), .frame_id(frame_id), .key_n(key_n), .hit(hit),
    .pipe_passed(pipe_passed), .frame_tick(frame_tick), .flap(flap),
    .world_run(world_run), .bird_run(bird_run), .game_state(game_state),
    .score_ones(score_ones), .score_tens(score_tens)
`ifdef HIGH_SCORE_EN
    , .best_ones(best_ones), .best_tens(best_tens)
`endif
  );

  // Snapshot layout: {state[13:12], world_run[11], bird_run[10], frame_tick[9], flap[8], tens[7:4], ones[3:0]}
  localparam logic [13:0] M_ALL   = 14'h3fff;
  localparam logic [13:0] M_FLAP  = 14'h0100;
  localparam logic [13:0] M_PULSE = 14'h0300;

  typedef struct {
    string       name;
    logic [13:0] val;
    logic [13:0] msk;
  } exp_t;

  typedef struct {
    logic        rst, key_n, hit, pp, bump;
    logic [13:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [13:0] snap(input game_state_t st, input logic wr, input logic br,
                                       input logic ft, input logic fl, input logic [7:0] sc);
    return {st, wr, br, ft, fl, sc};
  endfunction

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [13:0] actual();
    return {game_state, world_run, bird_run, frame_tick, flap, score_tens, score_ones};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp,
                       input logic [13:0] msk);
    n_vec++;
    if (((act ^ exp) & msk) !== 14'h0) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (mask %h)", name, act, exp, msk);
    end
  endtask

  task automatic push(input string name, input logic [13:0] val, input logic [13:0] msk);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.msk  = msk;
    sb.push_back(e);
  endtask

  task automatic add(input logic r, input logic k, input logic h, input logic p, input logic b,
                     input logic [13:0] e);
    vec_t v;
    v.rst = r; v.key_n = k; v.hit = h; v.pp = p; v.bump = b; v.exp = e;
    vecs.push_back(v);
  endtask

  // One clock: optionally advance frame_id, then compare everything queued for this edge.
  task automatic step(input bit bump);
    exp_t e;
    if (bump) frame_id = frame_id + 32'd1;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, actual(), e.val, e.msk);
    end
  endtask

  // Debounced press and release; no frame advances, so flap must stay low throughout.
  task automatic press();
    key_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push("no flap while pressing", 14'h0, M_FLAP);
      step(1'b0);
    end
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push("no flap while releasing", 14'h0, M_FLAP);
      step(1'b0);
    end
  endtask

  task automatic tick_frame(input string name, input logic [13:0] e);
    push(name, e, M_ALL);
    step(1'b1);
    push({name, " pulse end"}, 14'h0, M_PULSE);
    step(1'b0);
  endtask

  task automatic start_game();
    press();
    push("game start", snap(PLAY, 1, 1, 0, 0, 8'h00), M_ALL);
    step(1'b0);
  endtask

  task automatic run_score(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      pipe_passed = 1'b1;
      push($sformatf("score %0d", i), snap(PLAY, 1, 1, 0, 0, bcd(i)), M_ALL);
      step(1'b0);
      pipe_passed = 1'b0;
      step(1'b0);
    end
  endtask

  task automatic die(input int sc);
    hit = 1'b1;
    push($sformatf("hit at %0d", sc), snap(DYING, 0, 1, 0, 0, bcd(sc)), M_ALL);
    step(1'b0);
    hit = 1'b0;
  endtask

  task automatic end_game(input int sc);
    tick_frame("dying t1", snap(DYING, 0, 1, 1, 0, bcd(sc)));
    tick_frame("dying t2", snap(DYING, 0, 1, 1, 0, bcd(sc)));
    tick_frame("dying t3", snap(OVER, 0, 0, 1, 0, bcd(sc)));
    for (int i = 1; i <= 5; i++) tick_frame("over tick", snap(OVER, 0, 0, 1, 0, bcd(sc)));
    press();
    push("over -> attract", snap(ATTRACT, 0, 0, 0, 0, bcd(sc)), M_ALL);
    step(1'b0);
  endtask

`ifdef HIGH_SCORE_EN
  task automatic check_best(input string name, input int sc);
    check(name, {6'b0, best_tens, best_ones}, {6'b0, bcd(sc)}, 14'h00ff);
  endtask
`endif

  initial begin
    // Reset with frame_id held at 7, short glitch, long press, first flap on next frame.
    for (int i = 0; i < 2; i++) add(1, 1, 0, 0, 0, snap(ATTRACT, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, snap(ATTRACT, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, snap(ATTRACT, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, snap(ATTRACT, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, snap(ATTRACT, 0, 0, 0, 0, 8'h00));
    add(0, 0, 0, 0, 0, snap(PLAY, 1, 1, 0, 0, 8'h00));
    for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, snap(PLAY, 1, 1, 0, 0, 8'h00));
    add(0, 1, 0, 0, 1, snap(PLAY, 1, 1, 1, 1, 8'h00));
    add(0, 1, 0, 0, 0, snap(PLAY, 1, 1, 0, 0, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      key_n       = vecs[i].key_n;
      hit         = vecs[i].hit;
      pipe_passed = vecs[i].pp;
      push($sformatf("vec%0d", i), vecs[i].exp, M_ALL);
      step(vecs[i].bump);
    end
    for (int i = 0; i < 4; i++) step(1'b0);

    // Three presses inside one frame collapse into a single flap.
    press();
    press();
    press();
    tick_frame("merged flap", snap(PLAY, 1, 1, 1, 1, 8'h00));
    tick_frame("no repeat flap", snap(PLAY, 1, 1, 1, 0, 8'h00));

    // Score to 42 (crossing 09 -> 10), then a one-cycle reset mid-game.
    run_score(1, 42);
    rst = 1'b1;
    push("rst mid-game", snap(ATTRACT, 0, 0, 0, 0, 8'h00), M_ALL);
    step(1'b0);
    rst = 1'b0;
    push("after rst", snap(ATTRACT, 0, 0, 0, 0, 8'h00), M_ALL);
    step(1'b0);
`ifdef HIGH_SCORE_EN
    check_best("best after rst", 0);
`endif

    // hit and pipe_passed together at 05: hit wins; then DYING/OVER timing.
    start_game();
    run_score(1, 5);
    pipe_passed = 1'b1;
    die(5);
    pipe_passed = 1'b0;
    tick_frame("dying t1 no flap", snap(DYING, 0, 1, 1, 0, bcd(5)));
    press();
    push("press in dying ignored", snap(DYING, 0, 1, 0, 0, bcd(5)), M_ALL);
    step(1'b0);
    tick_frame("dying t2", snap(DYING, 0, 1, 1, 0, bcd(5)));
    tick_frame("dying t3 -> over", snap(OVER, 0, 0, 1, 0, bcd(5)));
    tick_frame("over t1", snap(OVER, 0, 0, 1, 0, bcd(5)));
    tick_frame("over t2", snap(OVER, 0, 0, 1, 0, bcd(5)));
    press();
    push("early over press ignored", snap(OVER, 0, 0, 0, 0, bcd(5)), M_ALL);
    step(1'b0);
    for (int i = 3; i <= 5; i++) tick_frame("over tick", snap(OVER, 0, 0, 1, 0, bcd(5)));
    press();
    push("press after sat -> attract", snap(ATTRACT, 0, 0, 0, 0, bcd(5)), M_ALL);
    step(1'b0);
    tick_frame("attract holds score", snap(ATTRACT, 0, 0, 1, 0, bcd(5)));

    // Game ending at 42, then one ending at 17.
    start_game();
    run_score(1, 42);
    die(42);
`ifdef HIGH_SCORE_EN
    check_best("best after 42", 42);
`endif
    end_game(42);
    start_game();
    run_score(1, 17);
    die(17);
`ifdef HIGH_SCORE_EN
    check_best("best kept after 17", 42);
`endif
    end_game(17);

    // Saturation at 99.
    start_game();
    run_score(1, 99);
    pipe_passed = 1'b1;
    push("score saturates", snap(PLAY, 1, 1, 0, 0, bcd(99)), M_ALL);
    step(1'b0);
    pipe_passed = 1'b0;
    push("score held at 99", snap(PLAY, 1, 1, 0, 0, bcd(99)), M_ALL);
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1);
  end

endmodule
